i2c_wb_bridge: RTL and testbench

- Parametrised I2C-slave-to-Wishbone memory bridge (EEPROM-style emulation).
- Sits between an I2C slave byte controller (byte-level avail/req/start/stop strobes) and a Wishbone B3 master port on a byte-wide memory.
- Supports 1- or 2-byte word addresses, page-wrapped writes, sequential reads and write protect.
- Adds Wishbone error/timeout handling and a one-byte overrun buffer.

---
 rtl/i2c_wb_bridge_pkg.sv | 19 +
 rtl/i2c_wb_ptr.sv | 39 +++
 rtl/i2c_wb_bridge.sv | 232 +++++++++++++++++++++++
 tb/tb_i2c_wb_bridge.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_wb_bridge_pkg.sv
// Shared types and constants for the I2C-slave to Wishbone memory bridge.
package i2c_wb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WB_WR,
    ST_WB_RD
  } state_t;

  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [7:0] RD_ERR_DATA = 8'hFF;

  function automatic logic is_wb(input state_t s);
    return (s == ST_WB_WR) || (s == ST_WB_RD);
  endfunction

endpackage

// File: rtl/i2c_wb_ptr.sv
// Memory address pointer: byte-wise load (MSB first), page-wrapped and fully wrapped increment.
module i2c_wb_ptr #(
  parameter int AW        = 16,
  parameter int PAGE_SIZE = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic          inc_page_i,
  input  logic          inc_full_i,
  input  logic [7:0]    byte_i,
  output logic [AW-1:0] ptr_o
);

  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);

  logic [AW-1:0] ptr_q, ptr_d, ptr_inc;

  // Page increment keeps the upper bits so writes wrap inside the current page.
  always_comb begin
    ptr_inc = ptr_q + AW'(1);
    ptr_d   = ptr_q;
    if (load_i) begin
      ptr_d = AW'({ptr_q, byte_i});
    end else if (inc_full_i) begin
      ptr_d = ptr_inc;
    end else if (inc_page_i) begin
      ptr_d = (ptr_q & ~PAGE_MASK) | (ptr_inc & PAGE_MASK);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/i2c_wb_bridge.sv
// EEPROM-style bridge: I2C slave byte events drive single-byte Wishbone B3 cycles on a byte memory.
module i2c_wb_bridge #(
  parameter int AW         = 16,
  parameter int ADDR_BYTES = 2,
  parameter int PAGE_SIZE  = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          s_start_i,
  input  logic          s_stop_i,
  input  logic          s_dat_avail_i,
  input  logic [7:0]    s_dat_i,
  input  logic          s_dat_req_i,
  output logic [7:0]    s_dat_o,
  output logic          s_dat_vld_o,
  input  logic          wp_i,
  output logic [AW-1:0] wbm_adr_o,
  output logic [7:0]    wbm_dat_o,
  output logic          wbm_sel_o,
  output logic          wbm_we_o,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic [2:0]    wbm_cti_o,
  input  logic [7:0]    wbm_dat_i,
  input  logic          wbm_ack_i,
  input  logic          wbm_err_i,
  output logic          busy_o,
  output logic          err_o,
  output logic          wp_hit_o
);

  import i2c_wb_bridge_pkg::*;

  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [1:0] ADDR_LAST = 2'(ADDR_BYTES - 1);

  state_t     state_q, state_d, ret_q, ret_d;
  logic [1:0] acnt_q, acnt_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic [7:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic       vld_q, vld_d, err_q, err_d, wph_q, wph_d;
  logic       pend_vld_q, pend_vld_d, pend_rd_q, pend_rd_d;
  logic [7:0] pend_dat_q, pend_dat_d;
  logic       start_pend_q, start_pend_d, stop_pend_q, stop_pend_d;

  logic          ptr_load, ptr_inc_page, ptr_inc_full;
  logic [7:0]    ptr_byte;
  logic [AW-1:0] ptr;
  logic          in_wb, live_ev, ev_avail, ev_req, launched;
  logic          timed_out, done, fail, start_nx, stop_nx;

  i2c_wb_ptr #(.AW(AW), .PAGE_SIZE(PAGE_SIZE)) u_ptr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (ptr_load),
    .inc_page_i (ptr_inc_page),
    .inc_full_i (ptr_inc_full),
    .byte_i     (ptr_byte),
    .ptr_o      (ptr)
  );

  assign in_wb = is_wb(state_q);

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    acnt_d       = acnt_q;
    to_cnt_d     = to_cnt_q;
    wdat_d       = wdat_q;
    rdat_d       = rdat_q;
    vld_d        = 1'b0;
    wph_d        = 1'b0;
    err_d        = err_q;
    pend_vld_d   = pend_vld_q;
    pend_rd_d    = pend_rd_q;
    pend_dat_d   = pend_dat_q;
    ptr_load     = 1'b0;
    ptr_inc_page = 1'b0;
    ptr_inc_full = 1'b0;
    ptr_byte     = s_dat_i;
    live_ev      = s_dat_avail_i | s_dat_req_i;
    ev_avail     = 1'b0;
    ev_req       = 1'b0;
    launched     = 1'b0;
    timed_out    = 1'b0;
    done         = 1'b0;
    fail         = 1'b0;
    start_nx     = start_pend_q;
    stop_nx      = stop_pend_q;
    if (s_start_i) begin
      start_nx = 1'b1;
      stop_nx  = 1'b0;
    end
    if (s_stop_i) begin
      stop_nx  = 1'b1;
      start_nx = 1'b0;
    end
    start_pend_d = start_nx;
    stop_pend_d  = stop_nx;

    if (in_wb) begin
      // Byte events during a bus cycle go to the one-entry buffer; a second one is an overrun.
      if (live_ev) begin
        if (!pend_vld_q) begin
          pend_vld_d = 1'b1;
          pend_rd_d  = !s_dat_avail_i;
          pend_dat_d = s_dat_i;
        end else begin
          err_d = 1'b1;
        end
      end
      timed_out = (to_cnt_q == TO_LAST);
      done      = wbm_ack_i | wbm_err_i | timed_out;
      fail      = wbm_err_i | (timed_out & !wbm_ack_i);
      if (done) begin
        to_cnt_d = '0;
        state_d  = (state_q == ST_WB_WR) ? ST_WDATA : ret_q;
        if (fail) err_d = 1'b1;
        if (state_q == ST_WB_RD) begin
          ptr_inc_full = 1'b1;
          vld_d        = 1'b1;
          rdat_d       = fail ? RD_ERR_DATA : wbm_dat_i;
        end else begin
          ptr_inc_page = 1'b1;
        end
      end else begin
        to_cnt_d = to_cnt_q + 8'd1;
      end
    end else begin
      if (pend_vld_q) begin
        ev_avail   = !pend_rd_q;
        ev_req     = pend_rd_q;
        ptr_byte   = pend_dat_q;
        pend_vld_d = live_ev;
        pend_rd_d  = !s_dat_avail_i;
        pend_dat_d = s_dat_i;
      end else begin
        ev_avail = s_dat_avail_i;
        ev_req   = s_dat_req_i & !s_dat_avail_i;
      end

      if (ev_req) begin
        state_d  = ST_WB_RD;
        ret_d    = state_q;
        to_cnt_d = '0;
        launched = 1'b1;
      end else if (ev_avail) begin
        case (state_q)
          ST_ADDR: begin
            ptr_load = 1'b1;
            acnt_d   = acnt_q + 2'd1;
            if (acnt_q == ADDR_LAST) state_d = ST_WDATA;
          end
          ST_WDATA: begin
            if (wp_i) begin
              wph_d        = 1'b1;
              ptr_inc_page = 1'b1;
            end else begin
              wdat_d   = ptr_byte;
              to_cnt_d = '0;
              state_d  = ST_WB_WR;
              launched = 1'b1;
            end
          end
          default: ;
        endcase
      end

      // START/STOP take effect after the byte event, and wait out any cycle it launched.
      if (!launched) begin
        start_pend_d = 1'b0;
        stop_pend_d  = 1'b0;
        if (start_nx) begin
          state_d = ST_ADDR;
          acnt_d  = '0;
          err_d   = 1'b0;
        end else if (stop_nx) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ret_q        <= ST_IDLE;
      acnt_q       <= '0;
      to_cnt_q     <= '0;
      wdat_q       <= '0;
      rdat_q       <= '0;
      vld_q        <= 1'b0;
      err_q        <= 1'b0;
      wph_q        <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_rd_q    <= 1'b0;
      pend_dat_q   <= '0;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      acnt_q       <= acnt_d;
      to_cnt_q     <= to_cnt_d;
      wdat_q       <= wdat_d;
      rdat_q       <= rdat_d;
      vld_q        <= vld_d;
      err_q        <= err_d;
      wph_q        <= wph_d;
      pend_vld_q   <= pend_vld_d;
      pend_rd_q    <= pend_rd_d;
      pend_dat_q   <= pend_dat_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  assign wbm_cyc_o   = in_wb;
  assign wbm_stb_o   = in_wb;
  assign wbm_sel_o   = in_wb;
  assign wbm_we_o    = (state_q == ST_WB_WR);
  assign wbm_adr_o   = ptr;
  assign wbm_dat_o   = wdat_q;
  assign wbm_cti_o   = CTI_END;
  assign s_dat_o     = rdat_q;
  assign s_dat_vld_o = vld_q;
  assign err_o       = err_q;
  assign wp_hit_o    = wph_q;
  assign busy_o      = in_wb | pend_vld_q;

endmodule

// File: tb/tb_i2c_wb_bridge.sv
// Directed-plus-random bench for i2c_wb_bridge with a Wishbone memory slave and an address/data model.
module tb_i2c_wb_bridge;

  localparam int AW = 16, ADDR_BYTES = 2, PAGE = 32, TIMEOUT = 255;

  logic          clk_i, rst_i;
  logic          s_start_i, s_stop_i, s_dat_avail_i, s_dat_req_i, wp_i;
  logic [7:0]    s_dat_i, s_dat_o, wbm_dat_o, wbm_dat_i;
  logic          s_dat_vld_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o;
  logic [AW-1:0] wbm_adr_o;
  logic [2:0]    wbm_cti_o;
  logic          wbm_ack_i, wbm_err_i, busy_o, err_o, wp_hit_o;

  i2c_wb_bridge #(.AW(AW), .ADDR_BYTES(ADDR_BYTES), .PAGE_SIZE(PAGE), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .s_start_i(s_start_i), .s_stop_i(s_stop_i),
    .s_dat_avail_i(s_dat_avail_i), .s_dat_i(s_dat_i), .s_dat_req_i(s_dat_req_i),
    .s_dat_o(s_dat_o), .s_dat_vld_o(s_dat_vld_o), .wp_i(wp_i),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .busy_o(busy_o), .err_o(err_o), .wp_hit_o(wp_hit_o)
  );

  logic [7:0]  mem [65536];
  logic [7:0]  ref_mem [65536];
  logic [23:0] wr_q[$], exp_wr[$];
  logic [7:0]  rd_q[$], exp_rd[$], fixed_q[$];
  logic [15:0] rd_adr_q[$], exp_rdadr[$];
  int m_ptr, pass_cnt, fail_cnt, check_cnt, wph_cnt, cyc_cycles;
  int slave_delay, slave_mode, sl_wait;
  bit sl_acked;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Wishbone memory slave: ack/err after slave_delay wait cycles, or never (mode 2).
  initial begin
    wbm_ack_i = 0; wbm_err_i = 0; wbm_dat_i = 0; sl_wait = 0; sl_acked = 0;
    forever begin
      @(posedge clk_i); #2;
      if (sl_acked) begin
        wbm_ack_i = 0; wbm_err_i = 0; sl_acked = 0; sl_wait = 0;
      end else if (wbm_cyc_o && wbm_stb_o) begin
        if (sl_wait >= slave_delay && slave_mode != 2) begin
          if (slave_mode == 1) wbm_err_i = 1;
          else begin
            wbm_ack_i = 1;
            if (wbm_we_o) begin
              mem[wbm_adr_o] = wbm_dat_o;
              wr_q.push_back({wbm_adr_o, wbm_dat_o});
            end else begin
              wbm_dat_i = mem[wbm_adr_o];
              rd_adr_q.push_back(wbm_adr_o);
            end
          end
          sl_acked = 1;
        end else sl_wait++;
      end else sl_wait = 0;
    end
  end

  // Monitor on the falling edge: returned bytes, write-protect hits, bus-busy cycles.
  initial forever begin
    @(negedge clk_i);
    if (s_dat_vld_o) rd_q.push_back(s_dat_o);
    if (wp_hit_o) wph_cnt++;
    if (wbm_cyc_o) cyc_cycles++;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int page_next(input int p);
    return (p / PAGE) * PAGE + ((p % PAGE) + 1) % PAGE;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_i); #1;
  endtask

  // kind: 0 START, 1 STOP, 2 received byte, 3 read request
  task automatic applyStimulus(input int kind, input logic [7:0] b);
    case (kind)
      0: s_start_i = 1;
      1: s_stop_i = 1;
      2: begin s_dat_avail_i = 1; s_dat_i = b; end
      default: s_dat_req_i = 1;
    endcase
    cycle();
    s_start_i = 0; s_stop_i = 0; s_dat_avail_i = 0; s_dat_req_i = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin cycle(); n++; end
    checkOutput("idle_reached", {31'b0, busy_o}, 32'd0);
    cycle(); cycle();
  endtask

  task automatic send_addr(input logic [15:0] a);
    applyStimulus(0, 8'h00);
    applyStimulus(2, a[15:8]);
    applyStimulus(2, a[7:0]);
    m_ptr = int'(a);
  endtask

  task automatic write_bytes(input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (fixed_q.size() > 0) d = fixed_q.pop_front();
      else d = 8'($urandom);
      exp_wr.push_back({16'(m_ptr), d});
      ref_mem[16'(m_ptr)] = d;
      m_ptr = page_next(m_ptr);
      applyStimulus(2, d);
      wait_idle(50);
    end
  endtask

  task automatic read_bytes(input int n);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(ref_mem[16'(m_ptr)]);
      exp_rdadr.push_back(16'(m_ptr));
      m_ptr = (m_ptr + 1) % 65536;
      applyStimulus(3, 8'h00);
      wait_idle(50);
    end
  endtask

  task automatic check_writes(input string tag);
    checkOutput({tag, "_wr_count"}, wr_q.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++)
      checkOutput({tag, "_wr"}, {8'h00, wr_q[i]}, {8'h00, exp_wr[i]});
    wr_q.delete(); exp_wr.delete();
  endtask

  task automatic check_reads(input string tag);
    checkOutput({tag, "_rd_count"}, rd_q.size(), exp_rd.size());
    for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
      checkOutput({tag, "_rd_data"}, {24'h0, rd_q[i]}, {24'h0, exp_rd[i]});
    for (int i = 0; i < exp_rdadr.size() && i < rd_adr_q.size(); i++)
      checkOutput({tag, "_rd_adr"}, {16'h0, rd_adr_q[i]}, {16'h0, exp_rdadr[i]});
    rd_q.delete(); exp_rd.delete(); rd_adr_q.delete(); exp_rdadr.delete();
  endtask

  initial begin
    logic [15:0] a;
    logic [7:0]  b1, b2, b3;
    int n;
    pass_cnt = 0; fail_cnt = 0; check_cnt = 0; wph_cnt = 0; cyc_cycles = 0;
    slave_delay = 1; slave_mode = 0; m_ptr = 0;
    rst_i = 1; s_start_i = 0; s_stop_i = 0; s_dat_avail_i = 0; s_dat_req_i = 0;
    s_dat_i = 0; wp_i = 0;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    repeat (3) cycle();
    rst_i = 0;
    cycle();

    // Reset values
    checkOutput("rst_cyc", {31'b0, wbm_cyc_o}, 0);
    checkOutput("rst_stb", {31'b0, wbm_stb_o}, 0);
    checkOutput("rst_cti", {29'b0, wbm_cti_o}, 32'd7);
    checkOutput("rst_sdat", {24'b0, s_dat_o}, 0);
    checkOutput("rst_err", {31'b0, err_o}, 0);
    checkOutput("rst_busy", {31'b0, busy_o}, 0);
    checkOutput("rst_adr", {16'b0, wbm_adr_o}, 0);

    // Two-byte address 0x0123, fixed data, then read back with a repeated START
    $display("[TB] basic write at 0x0123");
    fixed_q.push_back(8'hA5); fixed_q.push_back(8'h5A);
    send_addr(16'h0123);
    write_bytes(2);
    applyStimulus(1, 8'h00);
    checkOutput("basic_err", {31'b0, err_o}, 0);
    check_writes("basic");
    send_addr(16'h0123);
    applyStimulus(0, 8'h00);
    read_bytes(2);
    applyStimulus(1, 8'h00);
    check_reads("basic");

    // Page wrap from 0x001E
    $display("[TB] page wrap at 0x001E");
    send_addr(16'h001E);
    write_bytes(4);
    applyStimulus(1, 8'h00);
    check_writes("page_wrap");

    // Random read at 0xFFFF wraps to 0x0000
    $display("[TB] random read across 0xFFFF");
    mem[16'hFFFF] = 8'h11; ref_mem[16'hFFFF] = 8'h11;
    mem[16'h0000] = 8'h22; ref_mem[16'h0000] = 8'h22;
    send_addr(16'hFFFF);
    applyStimulus(0, 8'h00);
    read_bytes(2);
    applyStimulus(0, 8'h00);
    read_bytes(1);
    applyStimulus(1, 8'h00);
    check_reads("wrap_read");

    // Write protect: no bus cycles, pointer still moves
    $display("[TB] write protect");
    wp_i = 1; wph_cnt = 0;
    send_addr(16'h0040);
    cyc_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2, 8'($urandom));
      m_ptr = page_next(m_ptr);
      wait_idle(50);
    end
    applyStimulus(1, 8'h00);
    wp_i = 0;
    checkOutput("wp_hits", wph_cnt, 3);
    checkOutput("wp_cyc_cycles", cyc_cycles, 0);
    check_writes("wp");
    applyStimulus(0, 8'h00);
    read_bytes(1);
    applyStimulus(1, 8'h00);
    check_reads("wp_read");

    // Randomized bursts checked against the model, then read back
    $display("[TB] random bursts");
    for (int k = 0; k < 4; k++) begin
      a = 16'($urandom);
      n = int'($urandom_range(1, 6));
      slave_delay = int'($urandom_range(0, 3));
      send_addr(a);
      write_bytes(n);
      applyStimulus(1, 8'h00);
      check_writes("rand");
      send_addr(a);
      applyStimulus(0, 8'h00);
      read_bytes(n);
      applyStimulus(1, 8'h00);
      check_reads("rand");
    end
    slave_delay = 1;

    // Read timeout: no ack ever
    $display("[TB] read timeout");
    slave_mode = 2;
    applyStimulus(0, 8'h00);
    cyc_cycles = 0;
    applyStimulus(3, 8'h00);
    wait_idle(400);
    m_ptr = (m_ptr + 1) % 65536;
    slave_mode = 0;
    checkOutput("to_cyc_cycles", cyc_cycles, TIMEOUT);
    checkOutput("to_err", {31'b0, err_o}, 1);
    checkOutput("to_rd_count", rd_q.size(), 1);
    if (rd_q.size() > 0) checkOutput("to_rd_data", {24'b0, rd_q[0]}, 32'hFF);
    rd_q.delete();
    applyStimulus(0, 8'h00);
    checkOutput("to_err_cleared", {31'b0, err_o}, 0);
    read_bytes(1);
    applyStimulus(1, 8'h00);
    check_reads("after_to");

    // Write answered with err: error flagged, pointer advances
    $display("[TB] write error response");
    a = 16'($urandom);
    send_addr(a);
    slave_mode = 1;
    applyStimulus(2, 8'($urandom));
    m_ptr = page_next(m_ptr);
    wait_idle(50);
    slave_mode = 0;
    checkOutput("werr_err", {31'b0, err_o}, 1);
    write_bytes(1);
    applyStimulus(1, 8'h00);
    check_writes("werr");

    // Slow write with three byte events: one buffered, one dropped
    $display("[TB] overrun during slow write");
    slave_delay = 9;
    a = 16'($urandom);
    send_addr(a);
    checkOutput("ovr_err_start", {31'b0, err_o}, 0);
    b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
    exp_wr.push_back({16'(m_ptr), b1}); ref_mem[16'(m_ptr)] = b1; m_ptr = page_next(m_ptr);
    exp_wr.push_back({16'(m_ptr), b2}); ref_mem[16'(m_ptr)] = b2; m_ptr = page_next(m_ptr);
    applyStimulus(2, b1);
    cycle();
    applyStimulus(2, b2);
    cycle();
    applyStimulus(2, b3);
    wait_idle(100);
    checkOutput("ovr_err", {31'b0, err_o}, 1);
    applyStimulus(1, 8'h00);
    check_writes("ovr");
    slave_delay = 1;

    // Asynchronous reset while a cycle is open
    $display("[TB] reset mid-cycle");
    slave_mode = 2;
    applyStimulus(0, 8'h00);
    applyStimulus(3, 8'h00);
    cycle(); cycle();
    checkOutput("mid_cyc_open", {31'b0, wbm_cyc_o}, 1);
    rst_i = 1;
    #1;
    checkOutput("mid_rst_cyc", {31'b0, wbm_cyc_o}, 0);
    checkOutput("mid_rst_stb", {31'b0, wbm_stb_o}, 0);
    checkOutput("mid_rst_adr", {16'b0, wbm_adr_o}, 0);
    cycle();
    rst_i = 0;
    slave_mode = 0;
    cycle();
    checkOutput("mid_rst_busy", {31'b0, busy_o}, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
